seq_checker: RTL and testbench
==============================

SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 SHALL have parameter LOCK_LEN, default 4: number of consecutive correct terms, counting the leading 0, before lock; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port valid_i  input  1  seq_i is sampled this cycle.
REQ-005 SHALL have port seq_i  input  32  incoming sequence term.
REQ-006 SHALL have port clear_i  input  1  synchronous return to HUNT; clears err_o and match_cnt_o.
REQ-007 SHALL have port locked_o  output  1  checker is locked to a Fibonacci stream.
REQ-008 SHALL have port err_o  output  1  sticky; a mismatch occurred while locked.
REQ-009 SHALL have port match_cnt_o  output  16  consecutive matched terms, saturating at 0xFFFF.
REQ-010 SHALL have port expected_o  output  32  next term the checker will accept.

Function
REQ-011 SHALL implement an FSM with states HUNT, TRACK, LOCKED, ERROR; held terms p, q (32 bit); expected = p+q modulo 2^32.
REQ-012 SHALL register all outputs; each reflects a sample from the cycle after valid_i was high.
REQ-013 HUNT: on valid_i with seq_i==0, SHALL go to TRACK with p=1, q=0 and count=1; any other sample is ignored.
REQ-014 TRACK, seq_i==expected: SHALL set p<=q, q<=seq_i, count+1; if the new count equals LOCK_LEN, SHALL go to LOCKED.
REQ-015 TRACK mismatch with seq_i==0: SHALL resynchronise in TRACK (p=1, q=0, count=1).
REQ-016 TRACK mismatch with seq_i!=0: SHALL go to HUNT with count=0.
REQ-017 LOCKED match: SHALL advance p, q and the saturating count; locked_o=1.
REQ-018 LOCKED mismatch: SHALL go to ERROR with err_o=1, locked_o=0; count is held.
REQ-019 ERROR: SHALL ignore valid_i until clear_i.
REQ-020 clear_i in any state: SHALL go to HUNT with count=0 and err_o=0; clear_i takes priority over a same-cycle valid_i, whose sample is discarded.
REQ-021 valid_i low: no state, term or count change; gaps of any length are allowed.
REQ-022 Arithmetic SHALL wrap modulo 2^32 with no overflow flag, so wrapped terms are accepted.
REQ-023 expected_o SHALL be p+q in TRACK and LOCKED, and 0 in HUNT and ERROR.
REQ-024 locked_o SHALL be 1 only in LOCKED.

Reset
REQ-025 reset_n low SHALL immediately force HUNT, p=q=0, locked_o=0, err_o=0, match_cnt_o=0, expected_o=0, including mid-operation.
REQ-026 The first sample SHALL be taken on the first rising edge after reset_n deasserts.

Structure
REQ-027 Package seq_pkg SHALL hold SEQ_W=32, CNT_W=16 and the state enum (HUNT, TRACK, LOCKED, ERROR).
REQ-028 SHALL be a single module with no sub-module; the bench supplies a Fibonacci source model as stimulus.

Verification
REQ-029 LOCK_LEN=4; reset, then feed 0,1,1,2 -> after the 2: locked_o=1, match_cnt_o=4, expected_o=3.
REQ-030 Locked; feed 3,5,9 -> after the 9: err_o=1, locked_o=0, match_cnt_o=6; feed 0 -> no change; pulse clear_i -> HUNT, err_o=0, match_cnt_o=0.
REQ-031 Feed 0,1,1,5 -> HUNT, match_cnt_o=0, err_o=0; then feed 7,0,1 -> TRACK, match_cnt_o=2, expected_o=1.
REQ-032 Feed 49 terms F0..F48; F47=2971215073, F48 wrapped=512559680 -> err_o=0, locked_o=1, match_cnt_o=49.
REQ-033 Feed 0,1,1,2 with idle gaps of 0..5 cycles, then assert clear_i and valid_i(seq_i=3) together -> locked, then HUNT with count 0.
REQ-034 Assert reset_n low mid-LOCKED, between clock edges -> all outputs are 0 before the next edge.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared widths and state encoding for the Fibonacci sequence checker.
package seq_pkg;

  localparam int SEQ_W = 32;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2,
    ERROR  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_checker.sv
// Checks an incoming 32-bit stream against the Fibonacci recurrence (mod 2^32),
// locks after LOCK_LEN consecutive correct terms and flags a sticky error on a miss while locked.
//
// state  | meaning
// HUNT   | waiting for a leading 0 to start tracking
// TRACK  | following the recurrence, not yet LOCK_LEN terms long
// LOCKED | locked to the stream; every valid term must match
// ERROR  | mismatch while locked; frozen until clear_i
module seq_checker
  import seq_pkg::*;
#(
  parameter int LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_i,
  input  logic [SEQ_W-1:0] seq_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic [SEQ_W-1:0] expected_o
);

  localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  seq_state_e       state, state_n;
  logic [SEQ_W-1:0] p, q, p_n, q_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SEQ_W-1:0] sum;

  assign sum = p + q;

  always_comb begin
    state_n = state;
    p_n     = p;
    q_n     = q;
    cnt_n   = cnt;
    if (clear_i) begin
      state_n = HUNT;
      p_n     = '0;
      q_n     = '0;
      cnt_n   = '0;
    end else if (valid_i) begin
      case (state)
        HUNT: begin
          if (seq_i == '0) begin
            state_n = TRACK;
            p_n     = SEQ_W'(1);
            q_n     = '0;
            cnt_n   = CNT_W'(1);
          end
        end
        TRACK: begin
          if (seq_i == sum) begin
            p_n   = q;
            q_n   = seq_i;
            cnt_n = cnt + CNT_W'(1);
            if (cnt_n == LOCK_CNT) state_n = LOCKED;
          end else if (seq_i == '0) begin
            // a fresh 0 may be the start of a new stream
            p_n   = SEQ_W'(1);
            q_n   = '0;
            cnt_n = CNT_W'(1);
          end else begin
            state_n = HUNT;
            p_n     = '0;
            q_n     = '0;
            cnt_n   = '0;
          end
        end
        LOCKED: begin
          if (seq_i == sum) begin
            p_n   = q;
            q_n   = seq_i;
            cnt_n = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
          end else begin
            state_n = ERROR;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs are registered from the next-state values so they line up with state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HUNT;
      p           <= '0;
      q           <= '0;
      cnt         <= '0;
      locked_o    <= 1'b0;
      err_o       <= 1'b0;
      match_cnt_o <= '0;
      expected_o  <= '0;
    end else begin
      state       <= state_n;
      p           <= p_n;
      q           <= q_n;
      cnt         <= cnt_n;
      locked_o    <= (state_n == LOCKED);
      err_o       <= (state_n == ERROR);
      match_cnt_o <= cnt_n;
      expected_o  <= ((state_n == TRACK) || (state_n == LOCKED)) ? (p_n + q_n) : '0;
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
// Directed, table-driven bench for seq_checker with LOCK_LEN=4.
module tb_seq_checker;

  logic        clk;
  logic        reset_n;
  logic        valid_i;
  logic [31:0] seq_i;
  logic        clear_i;
  logic        locked_o;
  logic        err_o;
  logic [15:0] match_cnt_o;
  logic [31:0] expected_o;

  int checks = 0;
  int errors = 0;

  seq_checker #(.LOCK_LEN(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .valid_i     (valid_i),
    .seq_i       (seq_i),
    .clear_i     (clear_i),
    .locked_o    (locked_o),
    .err_o       (err_o),
    .match_cnt_o (match_cnt_o),
    .expected_o  (expected_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] seq;
    logic        clear;
    logic        locked;
    logic        err;
    logic [15:0] cnt;
    logic [31:0] expv;
  } vec_t;

  vec_t vecs[19];
  logic [31:0] fib[50];

  function automatic vec_t mk(input logic v, input logic [31:0] s, input logic c,
                              input logic l, input logic e, input logic [15:0] n,
                              input logic [31:0] x);
    vec_t r;
    r.valid = v; r.seq = s; r.clear = c;
    r.locked = l; r.err = e; r.cnt = n; r.expv = x;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_all(input string tag, input logic l, input logic e,
                         input logic [15:0] n, input logic [31:0] x);
    chk({tag, ".locked"}, {31'd0, locked_o}, {31'd0, l});
    chk({tag, ".err"}, {31'd0, err_o}, {31'd0, e});
    chk({tag, ".cnt"}, {16'd0, match_cnt_o}, {16'd0, n});
    chk({tag, ".expected"}, expected_o, x);
  endtask

  task automatic step(input logic v, input logic [31:0] s, input logic c);
    @(negedge clk);
    valid_i = v; seq_i = s; clear_i = c;
    @(posedge clk);
    #1;
    valid_i = 1'b0; clear_i = 1'b0; seq_i = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    valid_i = 1'b0; seq_i = '0; clear_i = 1'b0; reset_n = 1'b0;

    fib[0] = 32'd0;
    fib[1] = 32'd1;
    for (int k = 2; k < 50; k++) fib[k] = fib[k-1] + fib[k-2];

    // lock, error, clear, hunt/resync behaviour
    vecs[0]  = mk(1, 0, 0,  0, 0, 1, 1);
    vecs[1]  = mk(1, 1, 0,  0, 0, 2, 1);
    vecs[2]  = mk(1, 1, 0,  0, 0, 3, 2);
    vecs[3]  = mk(1, 2, 0,  1, 0, 4, 3);
    vecs[4]  = mk(1, 3, 0,  1, 0, 5, 5);
    vecs[5]  = mk(1, 5, 0,  1, 0, 6, 8);
    vecs[6]  = mk(1, 9, 0,  0, 1, 6, 0);
    vecs[7]  = mk(1, 0, 0,  0, 1, 6, 0);
    vecs[8]  = mk(0, 0, 1,  0, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0,  0, 0, 1, 1);
    vecs[10] = mk(1, 1, 0,  0, 0, 2, 1);
    vecs[11] = mk(1, 1, 0,  0, 0, 3, 2);
    vecs[12] = mk(1, 5, 0,  0, 0, 0, 0);
    vecs[13] = mk(1, 7, 0,  0, 0, 0, 0);
    vecs[14] = mk(1, 0, 0,  0, 0, 1, 1);
    vecs[15] = mk(1, 1, 0,  0, 0, 2, 1);
    vecs[16] = mk(0, 9, 0,  0, 0, 2, 1);
    vecs[17] = mk(1, 0, 0,  0, 0, 1, 1);
    vecs[18] = mk(1, 1, 0,  0, 0, 2, 1);

    #12;
    chk_all("reset", 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].valid, vecs[i].seq, vecs[i].clear);
      chk_all($sformatf("vec%0d", i), vecs[i].locked, vecs[i].err, vecs[i].cnt, vecs[i].expv);
    end

    // long run through 32-bit wrap
    step(0, 0, 1);
    for (int i = 0; i < 49; i++) begin
      if (i == 47) chk("wrap.exp47", expected_o, 32'd2971215073);
      if (i == 48) chk("wrap.exp48", expected_o, 32'd512559680);
      step(1, fib[i], 0);
      chk($sformatf("wrap.cnt%0d", i), {16'd0, match_cnt_o}, i + 1);
    end
    chk_all("wrap.end", 1, 0, 49, fib[49]);

    // gaps between terms, then clear beats a same-cycle valid
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      idle(i + (i == 3 ? 2 : 0));
      step(1, fib[i] + (i == 3 ? 32'd1 : 32'd0) - (i == 3 ? 32'd1 : 32'd0), 0);
    end
    chk_all("gap.locked", 1, 0, 4, 3);
    step(1, 3, 1);
    chk_all("gap.clear", 0, 0, 0, 0);
    step(1, 3, 0);
    chk_all("gap.hunt_ignore", 0, 0, 0, 0);

    // asynchronous reset mid-LOCKED
    for (int i = 0; i < 4; i++) step(1, fib[i], 0);
    chk_all("arst.pre", 1, 0, 4, 3);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk_all("arst.now", 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 0, 0);
    chk_all("arst.first", 0, 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
